my_reg_bank: RTL and testbench

MY_REG_BANK -- requirements
Module: my_reg_bank

---
 rtl/my_reg_bank.sv | 114 +++++++++++
 tb/tb_my_reg_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_reg_bank.sv
// Parameterised register bank with a registered functional read/write port
// and CHAINS parallel scan chains threaded through the registers for test access.
module my_reg_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CHAINS = 1,
    localparam int unsigned AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned K     = DEPTH / CHAINS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic [CHAINS-1:0] scan_in,
    input  logic              scan_en,
    input  logic              test_mode,
    output logic [CHAINS-1:0] scan_out
);

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    // Elaboration-time parameter sanity
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("my_reg_bank: WIDTH out of range");
    end
    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("my_reg_bank: DEPTH out of range");
    end
    if (CHAINS < 1 || (DEPTH % CHAINS) != 0) begin : g_bad_chains
        $error("my_reg_bank: DEPTH must be a multiple of CHAINS");
    end

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;
    logic             rd_valid_q;
    logic             rd_valid_d;

    logic             func_mode;
    logic             shift_en;
    logic             wr_hit;
    logic             rd_in_range;
    logic [DEPTH-1:0] shift_bit;

    assign func_mode   = !test_mode;
    assign shift_en    = test_mode && scan_en;
    assign wr_hit      = func_mode && wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

    // Bit entering each register's MSB: chain heads take scan_in, the rest
    // take the LSB of the register one chain-step closer to the head.
    for (genvar i = 0; i < DEPTH; i++) begin : g_link
        if (i < CHAINS) begin : g_head
            assign shift_bit[i] = scan_in[i];
        end else begin : g_body
            assign shift_bit[i] = regs_q[i - CHAINS][0];
        end
    end

    for (genvar c = 0; c < CHAINS; c++) begin : g_sout
        assign scan_out[c] = regs_q[c + (K - 1) * CHAINS][0];
    end

    // Register next state: scan shift has priority, functional write otherwise
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (shift_en) begin
                regs_d[i] = WIDTH'({shift_bit[i], regs_q[i]} >> 1);
            end else if (wr_hit && (AW'(i) == wr_addr)) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Read path samples pre-write contents, giving read-before-write
    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (func_mode && rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
            if (rd_in_range) begin
                rd_data_d = regs_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_my_reg_bank.sv
// Bench for my_reg_bank: three configurations driven in lockstep and checked
// every cycle against a chain-vector level model, plus hand-computed checks.
module tb_my_reg_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [1:0] rd_addr = '0;
    logic       scan_en = 1'b0;
    logic       test_mode = 1'b0;
    logic [0:0] si0 = '0;
    logic [1:0] si1 = '0;
    logic [0:0] si2 = '0;

    logic [7:0] rdd0, rdd1, rdd2;
    logic       rdv0, rdv1, rdv2;
    logic [0:0] so0, so2;
    logic [1:0] so1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    my_reg_bank #(.WIDTH(8), .DEPTH(4), .CHAINS(1)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd0), .rd_valid(rdv0),
        .scan_in(si0), .scan_en(scan_en), .test_mode(test_mode), .scan_out(so0));

    my_reg_bank #(.WIDTH(8), .DEPTH(4), .CHAINS(2)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd1), .rd_valid(rdv1),
        .scan_in(si1), .scan_en(scan_en), .test_mode(test_mode), .scan_out(so1));

    my_reg_bank #(.WIDTH(8), .DEPTH(3), .CHAINS(1)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd2), .rd_valid(rdv2),
        .scan_in(si2), .scan_en(scan_en), .test_mode(test_mode), .scan_out(so2));

    typedef struct packed {
        logic [3:0][7:0] r;
        logic [7:0]      rd_data;
        logic            rd_valid;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;
    mdl_t m2 = '0;

    // Chain c as one integer: reg[c] most significant, last link least
    function automatic logic [63:0] chain_vec(mdl_t m, int depth, int chains, int c);
        logic [63:0] v = '0;
        for (int j = 0; j < depth / chains; j++) begin
            v = (v << 8) | 64'(m.r[c + j * chains]);
        end
        return v;
    endfunction

    function automatic logic [1:0] so_model(mdl_t m, int depth, int chains);
        logic [1:0] s = '0;
        for (int c = 0; c < chains; c++) begin
            s[c] = chain_vec(m, depth, chains, c) % 2 == 1;
        end
        return s;
    endfunction

    function automatic mdl_t step(mdl_t m, int depth, int chains, logic [1:0] si,
                                  logic tm, logic se, logic we, logic [1:0] wa,
                                  logic [7:0] wd, logic re, logic [1:0] ra);
        mdl_t n = m;
        int k = depth / chains;
        logic [63:0] v;
        if (tm) begin
            n.rd_valid = 1'b0;
            if (se) begin
                for (int c = 0; c < chains; c++) begin
                    v = chain_vec(m, depth, chains, c);
                    v = (v >> 1) | (64'(si[c]) << (k * 8 - 1));
                    for (int j = 0; j < k; j++) begin
                        n.r[c + j * chains] = 8'(v >> ((k - 1 - j) * 8));
                    end
                end
            end
        end else begin
            n.rd_valid = re;
            if (re) n.rd_data = (int'(ra) < depth) ? m.r[ra] : 8'h00;
            if (we && int'(wa) < depth) n.r[wa] = wd;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= '0;
            m1 <= '0;
            m2 <= '0;
        end else begin
            m0 <= step(m0, 4, 1, {1'b0, si0}, test_mode, scan_en, wr_en, wr_addr, wr_data, rd_en, rd_addr);
            m1 <= step(m1, 4, 2, si1, test_mode, scan_en, wr_en, wr_addr, wr_data, rd_en, rd_addr);
            m2 <= step(m2, 3, 1, {1'b0, si2}, test_mode, scan_en, wr_en, wr_addr, wr_data, rd_en, rd_addr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("u0_rd_valid", 64'(rdv0), 64'(m0.rd_valid));
        chk("u0_rd_data",  64'(rdd0), 64'(m0.rd_data));
        chk("u0_scan_out", 64'(so0),  64'(so_model(m0, 4, 1)));
        chk("u1_rd_valid", 64'(rdv1), 64'(m1.rd_valid));
        chk("u1_rd_data",  64'(rdd1), 64'(m1.rd_data));
        chk("u1_scan_out", 64'(so1),  64'(so_model(m1, 4, 2)));
        chk("u2_rd_valid", 64'(rdv2), 64'(m2.rd_valid));
        chk("u2_rd_data",  64'(rdd2), 64'(m2.rd_data));
        chk("u2_scan_out", 64'(so2),  64'(so_model(m2, 3, 1)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic re, input logic [1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        cyc();
    endtask

    logic [31:0] pat;
    logic [31:0] c0;
    logic [15:0] c1a, c1b;

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_async_rd_valid", 64'(rdv0), 64'h0);
        chk("rst_async_rd_data",  64'(rdd0), 64'h0);
        chk("rst_async_scan_out", 64'(so0),  64'h0);
        cyc(); cyc();
        reset = 1'b0;

        // Write then read with one cycle latency, then hold
        op(1, 2'd2, 8'hA5, 0, 2'd0);
        op(0, 2'd0, 8'h00, 1, 2'd2);
        chk("rd_lat_valid", 64'(rdv0), 64'h1);
        chk("rd_lat_data",  64'(rdd0), 64'hA5);
        op(0, 2'd0, 8'h00, 0, 2'd0);
        chk("rd_idle_valid", 64'(rdv0), 64'h0);
        chk("rd_idle_hold",  64'(rdd0), 64'hA5);

        // Read-before-write on the same address
        op(1, 2'd1, 8'h3C, 1, 2'd1);
        chk("rbw_old", 64'(rdd0), 64'h00);
        op(0, 2'd0, 8'h00, 1, 2'd1);
        chk("rbw_new", 64'(rdd0), 64'h3C);

        // Out-of-range write/read on the DEPTH=3 instance
        op(1, 2'd3, 8'hFF, 0, 2'd0);
        op(0, 2'd0, 8'h00, 1, 2'd3);
        chk("oor_rd_data",  64'(rdd2), 64'h00);
        chk("oor_rd_valid", 64'(rdv2), 64'h1);
        chk("inrange_d4",   64'(rdd0), 64'hFF);
        op(0, 2'd0, 8'h00, 1, 2'd2);
        chk("oor_no_side_effect", 64'(rdd2), 64'hA5);

        for (int a = 0; a < 4; a++) op(0, 2'd0, 8'h00, 1, 2'(a));
        op(0, 2'd0, 8'h00, 0, 2'd0);

        // scan_en is ignored in functional mode
        scan_en = 1'b1; si0 = 1'b1; si1 = 2'b11; si2 = 1'b1;
        op(1, 2'd0, 8'h5A, 1, 2'd0);
        chk("func_scan_ign_rbw", 64'(rdd0), 64'h00);
        op(0, 2'd0, 8'h00, 1, 2'd0);
        chk("func_scan_ign", 64'(rdd0), 64'h5A);
        scan_en = 1'b0;

        // Test mode: functional strobes ignored, capture-hold
        test_mode = 1'b1;
        op(1, 2'd0, 8'h77, 1, 2'd1);
        chk("tm_rd_valid", 64'(rdv0), 64'h0);
        op(0, 2'd0, 8'h00, 0, 2'd0);
        test_mode = 1'b0;
        op(0, 2'd0, 8'h00, 1, 2'd0);
        chk("tm_hold", 64'(rdd0), 64'h5A);

        for (int a = 0; a < 4; a++) op(1, 2'(a), 8'(8'h11 * (a + 1)), 0, 2'd0);

        // 32-bit shift: DEADBEEF LSB-first into u0, zeros into u1
        pat = 32'hDEADBEEF;
        c0 = '0; c1a = '0; c1b = '0;
        wr_en = 1'b0; rd_en = 1'b0;
        test_mode = 1'b1; scan_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            c0[i] = so0[0];
            if (i < 16) begin
                c1a[i] = so1[0];
                c1b[i] = so1[1];
            end
            si0[0] = pat[i];
            si1 = 2'b00;
            si2[0] = pat[31 - i];
            cyc();
        end
        chk("scan_out_stream_c1", 64'(c0),  64'h11223344);
        chk("scan_out_stream_ch0", 64'(c1a), 64'h1133);
        chk("scan_out_stream_ch1", 64'(c1b), 64'h2244);
        test_mode = 1'b0; scan_en = 1'b0;
        op(0, 2'd0, 8'h00, 1, 2'd0);
        chk("scan_reg0", 64'(rdd0), 64'hDE);
        op(0, 2'd0, 8'h00, 1, 2'd3);
        chk("scan_reg3", 64'(rdd0), 64'hEF);
        op(0, 2'd0, 8'h00, 1, 2'd1);
        op(0, 2'd0, 8'h00, 1, 2'd2);

        // Partial shift then stop and hold
        test_mode = 1'b1; scan_en = 1'b1; si0 = 1'b1; si1 = 2'b10; si2 = 1'b0;
        repeat (3) cyc();
        scan_en = 1'b0;
        repeat (2) cyc();
        test_mode = 1'b0; scan_en = 1'b1;
        op(0, 2'd0, 8'h00, 1, 2'd0);
        chk("partial_shift_reg0", 64'(rdd0), 64'hFB);
        for (int a = 1; a < 4; a++) op(0, 2'd0, 8'h00, 1, 2'(a));
        scan_en = 1'b0;
        op(0, 2'd0, 8'h00, 1, 2'd0);

        // Async reset mid-shift with a write pending
        test_mode = 1'b1; scan_en = 1'b1; si0 = 1'b1; si1 = 2'b11; si2 = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
        cyc(); cyc();
        #3 reset = 1'b1;
        #1;
        chk("midrst_u0_scan_out", 64'(so0),  64'h0);
        chk("midrst_u0_rd_data",  64'(rdd0), 64'h0);
        chk("midrst_u0_rd_valid", 64'(rdv0), 64'h0);
        chk("midrst_u1_scan_out", 64'(so1),  64'h0);
        chk("midrst_u2_scan_out", 64'(so2),  64'h0);
        cyc();
        reset = 1'b0;
        test_mode = 1'b0; scan_en = 1'b0;
        op(0, 2'd0, 8'h00, 1, 2'd0);
        chk("postrst_reg0", 64'(rdd0), 64'h00);
        for (int a = 1; a < 4; a++) op(0, 2'd0, 8'h00, 1, 2'(a));
        op(0, 2'd0, 8'h00, 0, 2'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
